// File: rtl/extio8x4_target_rx.sv
// rtl/extio8x4_target_rx.sv - extio 8-over-4 target receive path: nibble req/ack handshake to AXI-Stream byte output.
// Optional nibble timeout compiled in with EXTIO8X4_TARGET_TIMEOUT_EN.
module extio8x4_target_rx #(
  parameter int LO_FIRST       = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       testmode,
  input  logic       ioreq_a,
  input  logic [3:0] iodata_a,
  output logic       ioack,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       rx_timeout
);

  typedef enum logic {ST_FIRST, ST_SECOND} state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_req_sync;
  logic [3:0] r_data_sync0;
  logic [3:0] r_data_sync1;
  logic       r_ioack;
  logic [3:0] r_nib;
  logic [7:0] r_tdata;
  logic       r_tvalid;
  logic       r_rx_timeout;

  logic       w_req_s;
  logic [3:0] w_data_s;
  logic       w_pend;
  logic       w_buf_free;
  logic       w_cap_first;
  logic       w_load_byte;
  logic       w_timeout;
  logic [7:0] w_byte;

  // Test mode bypasses both sync stages so scan sees the pins directly.
  assign w_req_s    = testmode ? ioreq_a  : r_req_sync[1];
  assign w_data_s   = testmode ? iodata_a : r_data_sync1;
  assign w_pend     = (w_req_s != r_ioack);
  assign w_buf_free = !r_tvalid || m_axis_tready;
  assign w_byte     = (LO_FIRST != 0) ? {w_data_s, r_nib} : {r_nib, w_data_s};

`ifdef EXTIO8X4_TARGET_TIMEOUT_EN
  logic [15:0] r_cnt;

  assign w_timeout = (r_state == ST_SECOND) && !w_pend &&
                     (r_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 16'd0;
    end else if (w_cap_first) begin
      r_cnt <= 16'd0;
    end else if ((r_state == ST_SECOND) && !w_pend) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_FIRST;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cap_first = 1'b0;
    w_load_byte = 1'b0;
    case (r_state)
      ST_FIRST: begin
        if (w_pend) begin
          w_cap_first = 1'b1;
          w_state_nxt = ST_SECOND;
        end
      end
      ST_SECOND: begin
        if (w_pend && w_buf_free) begin
          w_load_byte = 1'b1;
          w_state_nxt = ST_FIRST;
        end else if (w_timeout) begin
          w_state_nxt = ST_FIRST;
        end
      end
      default: w_state_nxt = ST_FIRST;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req_sync   <= 2'b00;
      r_data_sync0 <= 4'h0;
      r_data_sync1 <= 4'h0;
      r_ioack      <= 1'b0;
      r_nib        <= 4'h0;
      r_tdata      <= 8'h00;
      r_tvalid     <= 1'b0;
      r_rx_timeout <= 1'b0;
    end else begin
      r_req_sync   <= {r_req_sync[0], ioreq_a};
      r_data_sync0 <= iodata_a;
      r_data_sync1 <= r_data_sync0;
      r_rx_timeout <= w_timeout;
      if (w_cap_first) begin
        r_nib   <= w_data_s;
        r_ioack <= ~r_ioack;
      end
      // A new byte loading on the accept edge keeps tvalid high.
      if (w_load_byte) begin
        r_tdata  <= w_byte;
        r_tvalid <= 1'b1;
        r_ioack  <= ~r_ioack;
      end else if (r_tvalid && m_axis_tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign ioack         = r_ioack;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign rx_timeout    = r_rx_timeout;

endmodule

// File: tb/tb_extio8x4_target_rx.sv
// tb/tb_extio8x4_target_rx.sv - self-checking bench for extio8x4_target_rx (both nibble orders side by side).
module tb_extio8x4_target_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       testmode = 1'b0;
  logic       ioreq = 1'b0;
  logic [3:0] iodata = 4'h0;
  logic       tready = 1'b1;
  logic       ack_lo, ack_hi, tvalid_lo, tvalid_hi, tmo_lo, tmo_hi;
  logic [7:0] tdata_lo, tdata_hi;

  int n_tests = 0;
  int n_fail = 0;
  int hs_lo = 0;
  int hs_hi = 0;
  bit rnd = 1'b0;
  bit have_nib = 1'b0;
  logic [3:0] held_nib = 4'h0;
  logic [7:0] q_lo[$];
  logic [7:0] q_hi[$];

  always #5 clk = ~clk;

  extio8x4_target_rx #(.LO_FIRST(1), .TIMEOUT_CYCLES(8)) u_lo (
    .clk(clk), .reset(reset), .testmode(testmode), .ioreq_a(ioreq), .iodata_a(iodata),
    .ioack(ack_lo), .m_axis_tdata(tdata_lo), .m_axis_tvalid(tvalid_lo),
    .m_axis_tready(tready), .rx_timeout(tmo_lo)
  );

  extio8x4_target_rx #(.LO_FIRST(0), .TIMEOUT_CYCLES(8)) u_hi (
    .clk(clk), .reset(reset), .testmode(testmode), .ioreq_a(ioreq), .iodata_a(iodata),
    .ioack(ack_hi), .m_axis_tdata(tdata_hi), .m_axis_tvalid(tvalid_hi),
    .m_axis_tready(tready), .rx_timeout(tmo_hi)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: nibbles pair up in send order; each pair forms one byte per ordering.
  task automatic model_nib(input logic [3:0] n);
    if (!have_nib) begin
      have_nib = 1'b1;
      held_nib = n;
    end else begin
      q_lo.push_back({n, held_nib});
      q_hi.push_back({held_nib, n});
      have_nib = 1'b0;
    end
  endtask

  task automatic toggle_nib(input logic [3:0] n);
    iodata = n;
    @(posedge clk); #1;
    ioreq = ~ioreq;
    model_nib(n);
  endtask

  task automatic wait_ack(input string tag, input int exp_lat);
    int edges;
    edges = 0;
    while (ack_lo !== ioreq && edges < 300) begin
      @(posedge clk); #1;
      edges++;
      if (rnd) tready = 1'($urandom_range(0, 1));
    end
    check({tag, "_ack"}, {31'd0, ack_lo}, {31'd0, ioreq});
    check({tag, "_ack_hi"}, {31'd0, ack_hi}, {31'd0, ioreq});
    if (exp_lat > 0) check({tag, "_latency"}, edges, exp_lat);
  endtask

  task automatic send_nib(input string tag, input logic [3:0] n, input int exp_lat);
    toggle_nib(n);
    wait_ack(tag, exp_lat);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  always @(negedge clk) begin
    if (!reset && tvalid_lo && tready) begin
      hs_lo++;
      check("lo_expected", {31'd0, q_lo.size() > 0}, 32'd1);
      if (q_lo.size() > 0) check("lo_tdata", {24'd0, tdata_lo}, {24'd0, q_lo.pop_front()});
    end
    if (!reset && tvalid_hi && tready) begin
      hs_hi++;
      check("hi_expected", {31'd0, q_hi.size() > 0}, 32'd1);
      if (q_hi.size() > 0) check("hi_tdata", {24'd0, tdata_hi}, {24'd0, q_hi.pop_front()});
    end
  end

  initial begin
    int edges;
    int hs0;
    #1;
    check("rst_ack", {31'd0, ack_lo}, 32'd0);
    check("rst_tvalid", {30'd0, tvalid_lo, tvalid_hi}, 32'd0);
    check("rst_tdata", {16'd0, tdata_lo, tdata_hi}, 32'd0);
    check("rst_timeout", {30'd0, tmo_lo, tmo_hi}, 32'd0);
    idle(3);
    reset = 1'b0;

    // Basic byte: 0x5 then 0xA
    send_nib("b1n0", 4'h5, 3);
    send_nib("b1n1", 4'hA, 3);
    idle(3);
    check("b1_hs_lo", hs_lo, 1);
    check("b1_hs_hi", hs_hi, 1);
    check("b1_tvalid_low", {31'd0, tvalid_lo}, 32'd0);

    // Backpressure: 0x12 held, 0x34 stalls on second nibble
    tready = 1'b0;
    send_nib("bp_n0", 4'h2, 3);
    send_nib("bp_n1", 4'h1, 3);
    check("bp_held_lo", {23'd0, tvalid_lo, tdata_lo}, {23'd0, 1'b1, 8'h12});
    check("bp_held_hi", {23'd0, tvalid_hi, tdata_hi}, {23'd0, 1'b1, 8'h21});
    send_nib("bp_n2", 4'h4, 3);
    toggle_nib(4'h3);
    idle(10);
    check("bp_stall_ack", {31'd0, ack_lo}, {31'd0, ~ioreq});
    check("bp_stall_data", {24'd0, tdata_lo}, 32'h12);
    tready = 1'b1;
    wait_ack("bp_release", 1);
    check("bp_new_lo", {23'd0, tvalid_lo, tdata_lo}, {23'd0, 1'b1, 8'h34});
    check("bp_new_hi", {24'd0, tdata_hi}, 32'h43);
    idle(3);
    check("bp_hs_lo", hs_lo, 3);

    // Test mode: synchronisers bypassed
    testmode = 1'b1;
    send_nib("tm_n0", 4'h3, 1);
    send_nib("tm_n1", 4'h6, 1);
    idle(3);
    testmode = 1'b0;
    idle(2);

    // Reset after first nibble of 0x7C
    send_nib("rs_n0", 4'hC, 3);
    reset = 1'b1;
    ioreq = 1'b0;
    have_nib = 1'b0;
    #1;
    check("rs_ack", {31'd0, ack_lo}, 32'd0);
    check("rs_tvalid", {31'd0, tvalid_lo}, 32'd0);
    idle(2);
    reset = 1'b0;
    send_nib("rs_n1", 4'h1, 3);
    send_nib("rs_n2", 4'h8, 3);
    idle(3);

    // Random nibbles with random downstream ready
    rnd = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send_nib("rnd", 4'($urandom_range(0, 15)), 0);
      idle($urandom_range(0, 2));
    end
    rnd = 1'b0;
    tready = 1'b1;
    idle(5);
    check("rnd_drain_lo", q_lo.size(), 0);
    check("rnd_drain_hi", q_hi.size(), 0);

`ifdef EXTIO8X4_TARGET_TIMEOUT_EN
    hs0 = hs_lo;
    send_nib("to_n0", 4'h6, 3);
    edges = 0;
    while (!tmo_lo && edges < 50) begin @(posedge clk); #1; edges++; end
    check("to_edges", edges, 8);
    check("to_hi", {31'd0, tmo_hi}, 32'd1);
    have_nib = 1'b0;
    idle(1);
    check("to_pulse_width", {31'd0, tmo_lo}, 32'd0);
    check("to_no_byte", hs_lo, hs0);
    send_nib("to_n1", 4'h9, 3);
    send_nib("to_n2", 4'hE, 3);
    idle(3);
    check("to_byte_hs", hs_lo, hs0 + 1);
`else
    hs0 = hs_lo;
    send_nib("nt_n0", 4'h6, 3);
    idle(40);
    check("nt_timeout_low", {30'd0, tmo_lo, tmo_hi}, 32'd0);
    check("nt_no_byte", hs_lo, hs0);
    send_nib("nt_n1", 4'h9, 3);
    idle(3);
    check("nt_byte_hs", hs_lo, hs0 + 1);
`endif
    check("end_queue_lo", q_lo.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
